// File: rtl/msrv32_ahb_data_mem.sv
// AHB-Lite data memory for the msrv32 core: word array with byte-lane writes,
// programmable wait states, two-cycle ERROR response and write-to-read bypass.
module msrv32_ahb_data_mem #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_out,
    input  logic [1:0]  ms_riscv32_mp_data_htrans_out,
    input  logic        ms_riscv32_mp_dmwr_req_out,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    input  logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [31:0] ms_riscv32_mp_data_in,
    output logic        ms_riscv32_mp_data_hready_in,
    output logic        ms_riscv32_mp_hresp_in
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [2:0]    r_cnt;
    logic          r_hready;
    logic          r_hresp;
    logic [31:0]   r_rdata;
    logic          r_dp_valid;
    logic          r_dp_write;
    logic [AW-1:0] r_dp_idx;
    logic [3:0]    r_dp_mask;

    logic          w_active;
    logic          w_accept;
    logic          w_oor;
    logic [AW-1:0] w_idx;
    logic          w_commit;
    logic          w_bypass;
    logic [31:0]   w_merged;
    logic [31:0]   w_rd_word;

    assign w_active = (ms_riscv32_mp_data_htrans_out == 2'b10) ||
                      (ms_riscv32_mp_data_htrans_out == 2'b11);
    assign w_accept = r_hready && w_active;
    assign w_oor    = |(ms_riscv32_mp_dmaddr_out >> (AW + 2));
    assign w_idx    = ms_riscv32_mp_dmaddr_out[AW+1:2];
    assign w_commit = r_hready && r_dp_valid && r_dp_write;
    assign w_bypass = w_commit && (r_dp_idx == w_idx);
    assign w_rd_word = w_bypass ? w_merged : r_mem[w_idx];

    // Word as it will look after the completing write: used for bypass.
    always_comb begin
        w_merged = r_mem[r_dp_idx];
        for (int i = 0; i < 4; i++) begin
            if (r_dp_mask[i]) begin
                w_merged[8*i +: 8] = ms_riscv32_mp_dmdata_out[8*i +: 8];
            end
        end
    end

    // Array is never reset; a write lands only when its data phase completes.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_dp_mask[i]) begin
                    r_mem[r_dp_idx][8*i +: 8] <= ms_riscv32_mp_dmdata_out[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_hready   <= 1'b1;
            r_hresp    <= 1'b0;
            r_rdata    <= 32'd0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_mask  <= 4'd0;
        end else if (r_hready) begin
            // Previous data phase completes here; sample the next address phase.
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_hresp    <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_mask  <= 4'd0;
            if (w_accept && w_oor) begin
                r_state  <= S_ERR1;
                r_hready <= 1'b0;
                r_hresp  <= 1'b1;
                r_rdata  <= 32'd0;
            end else if (w_accept) begin
                r_dp_valid <= 1'b1;
                r_dp_write <= ms_riscv32_mp_dmwr_req_out;
                r_dp_idx   <= w_idx;
                r_dp_mask  <= ms_riscv32_mp_dmwr_mask_out;
                if (WAIT_STATES == 0) begin
                    r_hready <= 1'b1;
                    if (!ms_riscv32_mp_dmwr_req_out) begin
                        r_rdata <= w_rd_word;
                    end
                end else begin
                    r_state  <= S_WAIT;
                    r_hready <= 1'b0;
                    r_cnt    <= 3'(WAIT_STATES);
                end
            end else begin
                r_hready <= 1'b1;
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        if (!r_dp_write) begin
                            r_rdata <= r_mem[r_dp_idx];
                        end
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                end
            endcase
        end
    end

    assign ms_riscv32_mp_data_in        = r_rdata;
    assign ms_riscv32_mp_data_hready_in = r_hready;
    assign ms_riscv32_mp_hresp_in       = r_hresp;

endmodule

// File: doc/msrv32_ahb_data_mem.md
MSRV32_AHB_DATA_MEM -- requirements
Module: msrv32_ahb_data_mem

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words in the memory array; address index width = clog2(DEPTH).
REQ-002 Parameter WAIT_STATES, default 0, legal 0..7, number of hready-low cycles inserted in every OKAY data phase.
REQ-003 ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-high.
REQ-005 ms_riscv32_mp_dmaddr_out  input  32  byte address from core, address phase.
REQ-006 ms_riscv32_mp_data_htrans_out  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 ms_riscv32_mp_dmwr_req_out  input  1  1 = write, 0 = read, address phase.
REQ-008 ms_riscv32_mp_dmwr_mask_out  input  4  byte-lane write enables, address phase; bit i enables byte [8i+7:8i].
REQ-009 ms_riscv32_mp_dmdata_out  input  32  write data, data phase.
REQ-010 ms_riscv32_mp_data_in  output  32  read data to core, valid when hready_in=1 closing a read data phase.
REQ-011 ms_riscv32_mp_data_hready_in  output  1  transfer-done / ready, to core.
REQ-012 ms_riscv32_mp_hresp_in  output  1  0 OKAY, 1 ERROR, to core.

Function
REQ-013 Address phase SHALL be accepted only on a clock edge where hready_out=1 and htrans[1]=1 (NONSEQ or SEQ treated identically); addr, write flag and mask captured into data-phase registers.
REQ-014 IDLE/BUSY address phases SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-015 Word index = addr[clog2(DEPTH)+1:2]; addr[1:0] ignored; address with any bit set at or above bit clog2(DEPTH)+2 SHALL be out of range.
REQ-016 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-017 IDLE: hready=1, hresp=0; on accepted in-range transfer with WAIT_STATES=0 stay IDLE (data phase completes next cycle); with WAIT_STATES>0 go WAIT, load counter = WAIT_STATES; on accepted out-of-range transfer go ERR1.
REQ-018 WAIT: hready=0, hresp=0; counter decrements each cycle; at counter=1 next state IDLE (hready=1 completes phase); total data phase = WAIT_STATES+1 cycles.
REQ-019 ERR1: hready=0, hresp=1, next ERR2; ERR2: hready=1, hresp=1, next IDLE; ERROR transfers SHALL NOT modify memory and SHALL drive data_in=0.
REQ-020 Write SHALL commit at the edge ending the data phase (hready=1 cycle), using dmdata_out sampled on that edge, only lanes with mask bit 1; mask 0000 SHALL be a legal no-op write.
REQ-021 Read SHALL update data_in register at the edge ending the address phase (or last WAIT cycle), so data_in is valid in the hready=1 cycle.
REQ-022 Back-to-back write then read same word (read address phase coincides with write data-phase completion) SHALL return the merged word: new bytes for masked lanes, old bytes otherwise (bypass).
REQ-023 A new address phase MAY be accepted in the completing cycle of the previous data phase (pipelined); no idle cycle required.
REQ-024 data_in SHALL hold its last value between reads.

Reset
REQ-025 On rst=1 at an edge: state IDLE, counter 0, data-phase registers cleared (pending write discarded), hready=1, hresp=0, data_in=0.
REQ-026 Memory array contents SHALL NOT be reset; reset mid-WAIT or mid-ERR SHALL abort the transfer with no write.
REQ-027 Inputs during reset cycles SHALL be ignored; first transfer accepted on first edge with rst=0.

Verification
REQ-028 WAIT_STATES=0: write 0xDEADBEEF mask 1111 to 0x10, then read 0x10 -> each data phase 1 cycle, hready never low, data_in=0xDEADBEEF, hresp=0.
REQ-029 WAIT_STATES=3: read 0x20 holding 0x12345678 -> hready low exactly 3 cycles, then hready=1 with data_in=0x12345678.
REQ-030 Word 0x40=0x11223344; write 0xAABBCCDD mask 0101 to 0x40 immediately followed by read 0x40 -> data_in=0x11BB33DD (bypass).
REQ-031 DEPTH=1024: read addr 0x00001000 -> hready=0/hresp=1, then hready=1/hresp=1, data_in=0; following write to 0x1000 leaves all memory unchanged.
REQ-032 WAIT_STATES=3: start write 0xCAFEF00D to 0x8, assert rst in 2nd wait cycle -> next edge hready=1, hresp=0; later read 0x8 returns prior contents.
REQ-033 htrans=IDLE and BUSY cycles interleaved with NONSEQ reads -> IDLE/BUSY phases zero-wait OKAY, memory and data_in unchanged by them.
